// File: rtl/fp_mul_seq.sv
// Multi-cycle IEEE-754 multiplier: radix-2 shift-add mantissa, round-to-nearest-even,
// subnormal inputs flushed to zero, no subnormal outputs, valid/ready handshake.
module fp_mul_seq #(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23
) (
  input  logic                            in_clk,
  input  logic                            in_rst,
  input  logic                            in_valid,
  input  logic [EXP_WIDTH+MANT_WIDTH:0]   in_numA,
  input  logic [EXP_WIDTH+MANT_WIDTH:0]   in_numB,
  output logic                            out_ready,
  output logic                            out_valid,
  output logic [EXP_WIDTH+MANT_WIDTH:0]   out_result,
  output logic [3:0]                      out_flags
);

  localparam int DW = 1 + EXP_WIDTH + MANT_WIDTH;
  localparam int PW = 2 * (MANT_WIDTH + 1);
  localparam int XW = EXP_WIDTH + 2;
  localparam int CW = $clog2(MANT_WIDTH + 1);
  localparam logic signed [XW-1:0] BIAS    = XW'((1 << (EXP_WIDTH - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_WIDTH) - 1);
  localparam logic [DW-1:0] QNAN = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MULT, NORM, ROUND, DONE} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic                   sign_r;
  logic signed [XW-1:0]   exp_r;
  logic [MANT_WIDTH:0]    mant_a;
  logic [MANT_WIDTH:0]    mant_b;
  logic [PW-1:0]          prod;
  logic [MANT_WIDTH-1:0]  frac_r;
  logic                   guard_r;
  logic                   sticky_r;
  logic [DW-1:0]          res_r;
  logic [3:0]             res_flags;

  logic [EXP_WIDTH-1:0]   exp_a, exp_b;
  logic [MANT_WIDTH-1:0]  frac_a, frac_b;
  logic                   sgn, zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, special;
  logic [DW-1:0]          spec_res;
  logic [3:0]             spec_flags;

  assign exp_a   = in_numA[DW-2 -: EXP_WIDTH];
  assign exp_b   = in_numB[DW-2 -: EXP_WIDTH];
  assign frac_a  = in_numA[MANT_WIDTH-1:0];
  assign frac_b  = in_numB[MANT_WIDTH-1:0];
  assign sgn     = in_numA[DW-1] ^ in_numB[DW-1];
  assign zero_a  = (exp_a == '0);
  assign zero_b  = (exp_b == '0);
  assign inf_a   = (exp_a == '1) && (frac_a == '0);
  assign inf_b   = (exp_b == '1) && (frac_b == '0);
  assign nan_a   = (exp_a == '1) && (frac_a != '0);
  assign nan_b   = (exp_b == '1) && (frac_b != '0);
  assign special = zero_a || zero_b || (exp_a == '1) || (exp_b == '1);

  always_comb begin
    spec_flags = '0;
    spec_res   = {sgn, {(DW-1){1'b0}}};
    if (nan_a || nan_b) begin
      spec_res = QNAN;
    end else if (inf_a || inf_b) begin
      if (zero_a || zero_b) begin
        spec_res   = QNAN;
        spec_flags = 4'b1000;
      end else begin
        spec_res = {sgn, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
      end
    end
  end

  // Right-shifting accumulator: the upper half gathers partial products, the lower half fills from the top.
  logic [MANT_WIDTH+1:0] mult_sum;
  assign mult_sum = {1'b0, prod[PW-1:MANT_WIDTH+1]} + (mant_b[0] ? {1'b0, mant_a} : '0);

  logic [PW-2:0] norm;
  assign norm = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};

  logic                  rnd_inc;
  logic [MANT_WIDTH:0]   rnd_sum;
  logic signed [XW-1:0]  rnd_exp;
  assign rnd_inc = guard_r && (sticky_r || frac_r[0]);
  assign rnd_sum = {1'b0, frac_r} + (MANT_WIDTH+1)'(rnd_inc);
  assign rnd_exp = exp_r + XW'(rnd_sum[MANT_WIDTH]);

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state      <= IDLE;
      out_ready  <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
      cnt        <= '0;
      sign_r     <= 1'b0;
      exp_r      <= '0;
      mant_a     <= '0;
      mant_b     <= '0;
      prod       <= '0;
      frac_r     <= '0;
      guard_r    <= 1'b0;
      sticky_r   <= 1'b0;
      res_r      <= '0;
      res_flags  <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && out_ready) begin
            out_ready <= 1'b0;
            sign_r    <= sgn;
            exp_r     <= XW'(exp_a) + XW'(exp_b) - BIAS;
            mant_a    <= {1'b1, frac_a};
            mant_b    <= {1'b1, frac_b};
            prod      <= '0;
            // Specials wait one extra cycle in DONE so they present after a fixed two-cycle latency.
            if (special) begin
              res_r     <= spec_res;
              res_flags <= spec_flags;
              cnt       <= CW'(1);
              state     <= DONE;
            end else begin
              cnt   <= CW'(MANT_WIDTH);
              state <= MULT;
            end
          end
        end
        MULT: begin
          prod   <= {mult_sum, prod[MANT_WIDTH:1]};
          mant_b <= mant_b >> 1;
          if (cnt == '0) state <= NORM;
          else           cnt   <= cnt - 1'b1;
        end
        NORM: begin
          frac_r   <= norm[PW-2 -: MANT_WIDTH];
          guard_r  <= norm[PW-2-MANT_WIDTH];
          sticky_r <= |norm[PW-3-MANT_WIDTH:0];
          exp_r    <= exp_r + XW'(prod[PW-1]);
          state    <= ROUND;
        end
        ROUND: begin
          if (rnd_exp >= EXP_MAX) begin
            res_r     <= {sign_r, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
            res_flags <= 4'b0101;
          end else if (rnd_exp[XW-1] || (rnd_exp == '0)) begin
            res_r     <= {sign_r, {(DW-1){1'b0}}};
            res_flags <= 4'b0011;
          end else begin
            res_r     <= {sign_r, rnd_exp[EXP_WIDTH-1:0], rnd_sum[MANT_WIDTH-1:0]};
            res_flags <= {3'b000, guard_r | sticky_r};
          end
          state <= DONE;
        end
        DONE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            out_result <= res_r;
            out_flags  <= res_flags;
            out_valid  <= 1'b1;
            out_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Scoreboard bench for fp_mul_seq: single precision vectors, control cases and one half-precision op.
module tb_fp_mul_seq;

  logic        in_clk = 1'b0;
  logic        in_rst;
  logic        in_valid;
  logic [31:0] in_numA, in_numB;
  logic        out_ready, out_valid;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  logic        h_in_valid;
  logic [15:0] h_numA, h_numB;
  logic        h_ready, h_valid;
  logic [15:0] h_result;
  logic [3:0]  h_flags;

  always #5 in_clk = ~in_clk;

  fp_mul_seq #(.EXP_WIDTH(8), .MANT_WIDTH(23)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_valid(in_valid),
    .in_numA(in_numA), .in_numB(in_numB),
    .out_ready(out_ready), .out_valid(out_valid),
    .out_result(out_result), .out_flags(out_flags)
  );

  fp_mul_seq #(.EXP_WIDTH(5), .MANT_WIDTH(10)) dut_half (
    .in_clk(in_clk), .in_rst(in_rst), .in_valid(h_in_valid),
    .in_numA(h_numA), .in_numB(h_numB),
    .out_ready(h_ready), .out_valid(h_valid),
    .out_result(h_result), .out_flags(h_flags)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    int unsigned acc;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  always @(posedge in_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  always @(negedge in_clk) begin
    if (!in_rst && out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 32'(out_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result", out_result, mon_e.res);
        check("flags", 32'(out_flags), 32'(mon_e.flags));
        check("latency", cyc - mon_e.acc, mon_e.lat);
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic [3:0] fl, input int unsigned lat);
    int unsigned w = 0;
    while (!out_ready && w < 100) begin
      @(negedge in_clk);
      w++;
    end
    check("ready_wait", 32'(out_ready), 32'd1);
    in_numA  = a;
    in_numB  = b;
    in_valid = 1'b1;
    sb.push_back('{res, fl, cyc + 1, lat});
    @(negedge in_clk);
    in_valid = 1'b0;
    check("busy_ready", 32'(out_ready), 32'd0);
  endtask

  task automatic drain();
    int unsigned w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge in_clk);
      w++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  localparam int NV = 14;
  logic [31:0] va[NV] = '{32'h3FC00000, 32'hC0000000, 32'h3F800001, 32'h3F800003, 32'h3F800005,
                          32'h7F800000, 32'hFF800000, 32'h7F000000, 32'h00800000, 32'h7FC00001,
                          32'h80000000, 32'h00000001, 32'h7F800000, 32'h40000000};
  logic [31:0] vb[NV] = '{32'h40000000, 32'h40400000, 32'h3F800001, 32'h3FC00000, 32'h3FC00000,
                          32'h00000000, 32'h40000000, 32'h40000000, 32'h3F000000, 32'h3F800000,
                          32'h40000000, 32'hC0000000, 32'hFF800000, 32'hBF800000};
  logic [31:0] vr[NV] = '{32'h40400000, 32'hC0C00000, 32'h3F800002, 32'h3FC00004, 32'h3FC00008,
                          32'h7FC00000, 32'hFF800000, 32'h7F800000, 32'h00000000, 32'h7FC00000,
                          32'h80000000, 32'h80000000, 32'hFF800000, 32'hC0000000};
  logic [3:0]  vf[NV] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001,
                          4'b1000, 4'b0000, 4'b0101, 4'b0011, 4'b0000,
                          4'b0000, 4'b0000, 4'b0000, 4'b0000};
  int unsigned vl[NV] = '{27, 27, 27, 27, 27, 2, 2, 27, 27, 2, 2, 2, 2, 27};

  initial begin
    int unsigned w;
    int unsigned acc;
    in_rst = 1'b1; in_valid = 1'b0; in_numA = '0; in_numB = '0;
    h_in_valid = 1'b0; h_numA = '0; h_numB = '0;
    repeat (3) @(negedge in_clk);
    in_rst = 1'b0;
    check("rst_ready", 32'(out_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_flags", 32'(out_flags), 32'd0);

    for (int i = 0; i < NV; i++) begin
      send(va[i], vb[i], vr[i], vf[i], vl[i]);
      drain();
    end

    // Operands offered while busy must be dropped.
    send(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 27);
    repeat (3) @(negedge in_clk);
    in_numA = 32'h40400000; in_numB = 32'h40400000; in_valid = 1'b1;
    repeat (3) @(negedge in_clk);
    in_valid = 1'b0;
    check("busy_ignore_ready", 32'(out_ready), 32'd0);
    drain();
    repeat (35) @(negedge in_clk);

    // Reset during MULT aborts without a result.
    in_numA = 32'h3FC00000; in_numB = 32'h40000000; in_valid = 1'b1;
    @(negedge in_clk);
    in_valid = 1'b0;
    repeat (10) @(negedge in_clk);
    in_rst = 1'b1;
    @(negedge in_clk);
    in_rst = 1'b0;
    check("abort_ready", 32'(out_ready), 32'd1);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_result", out_result, 32'd0);
    check("abort_flags", 32'(out_flags), 32'd0);
    repeat (40) @(negedge in_clk);

    // Reset wins over a simultaneous valid.
    in_rst = 1'b1; in_valid = 1'b1;
    @(negedge in_clk);
    in_rst = 1'b0; in_valid = 1'b0;
    check("rst_vs_valid_ready", 32'(out_ready), 32'd1);
    repeat (40) @(negedge in_clk);

    h_numA = 16'h3C00; h_numB = 16'h4000; h_in_valid = 1'b1;
    acc = cyc + 1;
    @(negedge in_clk);
    h_in_valid = 1'b0;
    w = 0;
    while (!h_valid && w < 50) begin
      @(negedge in_clk);
      w++;
    end
    check("half_valid", 32'(h_valid), 32'd1);
    check("half_latency", cyc - acc, 32'd14);
    check("half_result", 32'(h_result), 32'h00004000);
    check("half_flags", 32'(h_flags), 32'd0);
    @(negedge in_clk);
    check("half_pulse", 32'(h_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mul_seq.md
Name: fp_mul_seq

Overview:
Parametrised, multi-cycle IEEE-754 multiplier for the FP unit. It is the successor to the combinational single-precision multiplier and adds the following:
- generic EXP_WIDTH/MANT_WIDTH, covering half, single and double precision
- an iterative shift-add mantissa datapath for small area
- round-to-nearest-even
- special-operand handling and exception flags
- a valid/ready handshake

It sits between the FP operand registers and the FP result writeback.

Parameters:
EXP_WIDTH, 8, exponent field width; bias = 2^(EXP_WIDTH-1)-1.
MANT_WIDTH, 23, stored fraction width (hidden bit excluded).
DATA_WIDTH is derived internally as 1+EXP_WIDTH+MANT_WIDTH and is not overridable.

Ports:
in_clk  input  1  clock; all state changes on rising edge.
in_rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands present.
in_numA  input  DATA_WIDTH  operand A, IEEE-754 packed.
in_numB  input  DATA_WIDTH  operand B.
out_ready  output  1  block idle; transfer occurs on an edge where in_valid && out_ready.
out_valid  output  1  one-cycle pulse, out_result/out_flags valid.
out_result  output  DATA_WIDTH  product.
out_flags  output  4  {invalid, overflow, underflow, inexact}.

Behaviour:
- Clock and reset: one clock, in_clk. Reset in_rst is synchronous, active-high.
- Reset values: state IDLE, out_ready=1, out_valid=0, out_result=0, out_flags=0, counter=0.
- States: IDLE, MULT, NORM, ROUND, DONE.
- IDLE:
  - On accept, latch both operands, drop out_ready, classify.
  - Special operands go straight to DONE with the result computed.
  - All other operands go to MULT.
- Input flushing: an exponent field of 0 (zero or subnormal) is treated as signed zero.
- MULT:
  - Radix-2 shift-add of {1,fracA}×{1,fracB} into a 2*(MANT_WIDTH+1)-bit product.
  - Runs exactly MANT_WIDTH+1 cycles, counted by a down-counter.
- Exponent arithmetic: expA+expB-bias, computed in EXP_WIDTH+2-bit signed.
- NORM:
  - If the product MSB is set, shift right 1 and add 1 to the exponent.
  - Extract the fraction, guard bit, and sticky bit (OR of the remaining bits).
- ROUND:
  - RNE: increment when guard && (sticky || lsb).
  - A mantissa carry-out renormalises and adds 1 to the exponent.
  - inexact = guard|sticky.
- Range checks after rounding:
  - Exponent ≥ 2^EXP_WIDTH-1: signed infinity, overflow=1, inexact=1.
  - Exponent ≤ 0: signed zero (no subnormal output), underflow=1, inexact=1.
- DONE:
  - out_valid=1 for exactly one cycle; the result register is loaded on entry.
  - Next state is IDLE, with out_ready=1 in the following cycle.
- Latency, counted from the accept edge to the edge that raises out_valid:
  - normal operands: MANT_WIDTH+4 cycles (27 at default)
  - special operands: 2 cycles
- Throughput: one operation per latency+1 cycles. in_valid is ignored while out_ready=0, and no operand is queued.
- Output hold: out_result and out_flags hold their last value until the next DONE.
- Special cases; sign = signA^signB except NaN:
  - Any NaN input gives canonical qNaN {0, all-ones exponent, fraction MSB=1, rest 0}; flags 0.
  - inf×zero gives canonical qNaN with invalid=1.
  - inf×finite-nonzero or inf×inf gives signed infinity; flags 0.
  - zero×finite gives signed zero; flags 0.
- Reset mid-operation: on the next edge, return to IDLE with reset values. No out_valid is issued for the aborted operation.
- Simultaneous in_rst and in_valid: reset wins and the operand is not accepted.

Test Plan:
- Normal case: 0x3FC00000 (1.5) × 0x40000000 (2.0) → out_result 0x40400000, flags 0000. out_valid exactly 27 cycles after accept, high for 1 cycle.
- Sign: 0xC0000000 (-2) × 0x40400000 (3) → 0xC0C00000, flags 0000.
- Rounding: 0x3F800001 × 0x3F800001 → 0x3F800002, inexact=1.
- Specials, each with latency 2:
  - 0x7F800000 × 0x00000000 → 0x7FC00000, invalid=1.
  - 0xFF800000 × 0x40000000 → 0xFF800000, flags 0.
- Overflow: 0x7F000000 × 0x40000000 → 0x7F800000, overflow=1, inexact=1.
- Underflow: 0x00800000 × 0x3F000000 → 0x00000000, underflow=1, inexact=1.
- Control: assert in_rst at MULT cycle 10 → next cycle out_ready=1, out_valid=0, out_result=0, with no later out_valid. Pulsing in_valid while busy is ignored.
- Half precision (EXP_WIDTH=5, MANT_WIDTH=10): 0x3C00 × 0x4000 → 0x4000, latency 14.
